nios2_debug_cmd_bridge: RTL and testbench
=========================================

NIOS2_DEBUG_CMD_BRIDGE -- requirements
Module: nios2_debug_cmd_bridge

Interface
REQ-001 SHALL have parameter DR_WIDTH, default 38: width of the debug data register and of cmd_data.
REQ-002 SHALL have parameter IR_WIDTH, default 2: instruction width; 2**IR_WIDTH action channels.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, legal 2..4: synchronizer depth for vs_udr and vs_uir.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, power of two >= 2: command queue depth.
REQ-005 SHALL have port clk, input, 1: sole clock; all flops rising-edge.
REQ-006 SHALL have port reset_n, input, 1: reset, asynchronous and active-low.
REQ-007 SHALL have port ir_in, input, IR_WIDTH: instruction from the shift domain; quasi-static, sampled only on the uir event.
REQ-008 SHALL have port sr, input, DR_WIDTH: shift register contents; quasi-static, sampled only on the udr event.
REQ-009 SHALL have port vs_udr, input, 1: asynchronous update-DR level.
REQ-010 SHALL have port vs_uir, input, 1: asynchronous update-IR level.
REQ-011 SHALL have port flush, input, 1: synchronous queue clear.
REQ-012 SHALL have port overflow_clr, input, 1: clears overflow.
REQ-013 SHALL have port cmd_ready, input, 1: consumer accepts the head command.
REQ-014 SHALL have port cmd_valid, output, 1: queue non-empty.
REQ-015 SHALL have port cmd_ir, output, IR_WIDTH: head command instruction.
REQ-016 SHALL have port cmd_data, output, DR_WIDTH: head command data (jdo equivalent).
REQ-017 SHALL have port take_action, output, 2**IR_WIDTH: one-hot action pulse.
REQ-018 SHALL have port take_no_action, output, 2**IR_WIDTH: one-hot no-action pulse.
REQ-019 SHALL have port fifo_level, output, clog2(FIFO_DEPTH)+1: current occupancy.
REQ-020 SHALL have port overflow, output, 1: sticky dropped-command flag.

Function
REQ-021 SHALL pass each of vs_udr and vs_uir through a SYNC_STAGES-flop chain, followed by a previous-value flop; event = last stage high and previous-value flop low.
REQ-022 SHALL suppress events until an arm counter sees SYNC_STAGES+1 edges after reset release; a level held high through reset SHALL produce no event.
REQ-023 On a uir event, SHALL latch ir_in into ir_q.
REQ-024 On a udr event, SHALL push {ir_q, sr}; if a uir event occurs in the same cycle, the push SHALL use the new ir_in value.
REQ-025 Push latency: with an empty queue and vs_udr rising, cmd_valid SHALL assert exactly SYNC_STAGES+1 clk edges after the first edge that samples vs_udr high.
REQ-026 cmd_valid = (fifo_level != 0); cmd_ir and cmd_data SHALL show the head entry and stay stable while cmd_valid && !cmd_ready.
REQ-027 Pop occurs on an edge where cmd_valid && cmd_ready; ordering SHALL be FIFO, and pointers SHALL wrap modulo FIFO_DEPTH.
REQ-028 Full queue with a push and no pop: the push SHALL be dropped, the queue left unchanged, and overflow set.
REQ-029 Full queue with push and pop in the same cycle: both SHALL succeed and fifo_level SHALL stay FIFO_DEPTH.
REQ-030 Empty queue with a push: no same-cycle pop is possible (cmd_valid is low).
REQ-031 fifo_level SHALL update by +1 on push only, -1 on pop only, and 0 on push+pop.
REQ-032 On each pop, the cycle after the pop edge SHALL pulse exactly one bit for one clk: take_action[cmd_ir] if cmd_data[DR_WIDTH-1]=1, else take_no_action[cmd_ir].
REQ-033 Back-to-back pops SHALL give back-to-back pulses, one per pop.
REQ-034 flush SHALL set fifo_level to 0 next edge and drop any same-cycle push and pop; flush pops SHALL generate no action pulse.
REQ-035 overflow SHALL clear on overflow_clr; if set and clear coincide, set SHALL win.

Reset
REQ-036 While reset_n=0, all flops SHALL be cleared immediately: sync chains, previous-value flops, arm counter, ir_q, pointers, pulse registers, overflow.
REQ-037 Reset outputs: cmd_valid=0, fifo_level=0, take_action=0, take_no_action=0, overflow=0, cmd_ir=0, cmd_data=0.
REQ-038 Reset asserted mid-operation SHALL discard queued commands without emitting pulses.

Verification
REQ-039 Defaults, ir_in=2'b01, uir pulse, sr=38'h20_0000_0ABC, udr pulse -> cmd_valid high 3 edges after vs_udr sampled; cmd_ir=1, cmd_data=38'h20_0000_0ABC; cmd_ready=1 -> take_action=4'b0010 for 1 cycle.
REQ-040 sr MSB=0, ir=3 popped -> take_no_action=4'b1000 pulse, take_action stays 0.
REQ-041 Five udr events, cmd_ready=0, FIFO_DEPTH=4 -> fifo_level=4, overflow=1, first four commands later popped in order; overflow_clr -> overflow=0.
REQ-042 Full queue, cmd_ready=1 while a push arrives -> fifo_level stays 4, overflow stays 0.
REQ-043 vs_udr held high across reset release -> no push, fifo_level=0; a later rising edge -> exactly one push.
REQ-044 Two queued commands, flush=1 -> fifo_level=0 next edge, no pulses; reset_n low mid-queue -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/nios2_debug_cmd_bridge.sv
// nios2_debug_cmd_bridge
//
// Moves debug commands from the JTAG shift domain into the clk domain.
// vs_uir / vs_udr are asynchronous update strobes. Each one goes through a
// synchronizer chain, a previous-value flop and an edge detector. A uir event
// latches the instruction. A udr event queues {instruction, shift data} into a
// small FIFO. Each command popped by the consumer produces a one-cycle,
// one-hot take_action or take_no_action pulse on the channel selected by its
// instruction. Which pulse fires depends on the data MSB.
//
// Ports
//   clk, reset_n        clock; asynchronous active-low reset
//   ir_in, sr           quasi-static instruction / shift register contents
//   vs_udr, vs_uir      asynchronous update-DR / update-IR levels
//   flush               synchronous queue clear (no pulses)
//   overflow_clr        clears the sticky overflow flag
//   cmd_ready           consumer accepts the head command
//   cmd_valid           queue non-empty
//   cmd_ir, cmd_data    head command (zero while the queue is empty)
//   take_action         one-hot pulse, popped command had data MSB = 1
//   take_no_action      one-hot pulse, popped command had data MSB = 0
//   fifo_level          current occupancy
//   overflow            sticky: a command was dropped on a full queue
module nios2_debug_cmd_bridge #(
  parameter int DR_WIDTH    = 38,
  parameter int IR_WIDTH    = 2,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [IR_WIDTH-1:0]           ir_in,
  input  logic [DR_WIDTH-1:0]           sr,
  input  logic                          vs_udr,
  input  logic                          vs_uir,
  input  logic                          flush,
  input  logic                          overflow_clr,
  input  logic                          cmd_ready,
  output logic                          cmd_valid,
  output logic [IR_WIDTH-1:0]           cmd_ir,
  output logic [DR_WIDTH-1:0]           cmd_data,
  output logic [2**IR_WIDTH-1:0]        take_action,
  output logic [2**IR_WIDTH-1:0]        take_no_action,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);

  localparam int NCH   = 2**IR_WIDTH;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LVL_W = AW + 1;
  localparam int ENT_W = IR_WIDTH + DR_WIDTH;

  logic [SYNC_STAGES-1:0] udr_sync, uir_sync;
  logic                   udr_prev, uir_prev;
  logic [2:0]             arm_cnt;
  logic                   armed;
  logic                   udr_evt_p1, uir_evt_p1;
  logic [IR_WIDTH-1:0]    ir_q;
  logic [IR_WIDTH-1:0]    push_ir;

  logic [ENT_W-1:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [LVL_W-1:0]       level;
  logic                   full, push_ok, pop_ok, drop;
  logic [ENT_W-1:0]       head;
  logic [NCH-1:0]         head_onehot;
  logic [NCH-1:0]         act_p1, nact_p1;

  // Events stay masked until the chains have flushed out whatever they held
  // at reset release. A level held high through reset therefore reaches the
  // previous-value flop before any edge can be reported.
  always_comb armed = (arm_cnt == 3'(SYNC_STAGES + 1));

  // ---- stage 0: synchronizers, edge detect, registered events ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      udr_sync   <= '0;
      uir_sync   <= '0;
      udr_prev   <= 1'b0;
      uir_prev   <= 1'b0;
      arm_cnt    <= '0;
      udr_evt_p1 <= 1'b0;
      uir_evt_p1 <= 1'b0;
    end else begin
      udr_sync   <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
      uir_sync   <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
      udr_prev   <= udr_sync[SYNC_STAGES-1];
      uir_prev   <= uir_sync[SYNC_STAGES-1];
      udr_evt_p1 <= armed & udr_sync[SYNC_STAGES-1] & ~udr_prev;
      uir_evt_p1 <= armed & uir_sync[SYNC_STAGES-1] & ~uir_prev;
      if (!armed) arm_cnt <= arm_cnt + 3'd1;
    end
  end

  // ---- stage 1: instruction latch and queue ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ir_q <= '0;
    else if (uir_evt_p1) ir_q <= ir_in;
  end

  // A coincident update-IR must be reflected in the command being queued.
  always_comb push_ir = uir_evt_p1 ? ir_in : ir_q;

  always_comb begin
    full      = (level == LVL_W'(FIFO_DEPTH));
    cmd_valid = (level != '0);
    pop_ok    = cmd_valid & cmd_ready & ~flush;
    push_ok   = udr_evt_p1 & ~flush & (~full | pop_ok);
    drop      = udr_evt_p1 & ~flush & full & ~pop_ok;
    head      = mem[rd_ptr];
    // Gate the head so stale storage never shows while the queue is empty.
    cmd_ir    = cmd_valid ? head[ENT_W-1 -: IR_WIDTH] : '0;
    cmd_data  = cmd_valid ? head[DR_WIDTH-1:0] : '0;
    head_onehot = NCH'(1) << cmd_ir;
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= {push_ir, sr};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Set has priority over clear so a drop in the clearing cycle is not lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)          overflow <= 1'b0;
    else if (drop)         overflow <= 1'b1;
    else if (overflow_clr) overflow <= 1'b0;
  end

  // ---- stage 2: action pulses, one cycle after each pop ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      act_p1  <= '0;
      nact_p1 <= '0;
    end else begin
      act_p1  <= (pop_ok &  cmd_data[DR_WIDTH-1]) ? head_onehot : '0;
      nact_p1 <= (pop_ok & ~cmd_data[DR_WIDTH-1]) ? head_onehot : '0;
    end
  end

  always_comb begin
    take_action    = act_p1;
    take_no_action = nact_p1;
    fifo_level     = level;
  end

endmodule

// File: tb/tb_nios2_debug_cmd_bridge.sv
module tb_nios2_debug_cmd_bridge;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [1:0]  ir_in = '0;
  logic [37:0] sr = '0;
  logic        vs_udr = 1'b0, vs_uir = 1'b0;
  logic        flush = 1'b0, overflow_clr = 1'b0, cmd_ready = 1'b0;
  logic        cmd_valid;
  logic [1:0]  cmd_ir;
  logic [37:0] cmd_data;
  logic [3:0]  take_action, take_no_action;
  logic [2:0]  fifo_level;
  logic        overflow;

  int n_cmp = 0;
  int n_err = 0;
  logic [39:0] sb[$];
  logic [1:0]  cur_ir = '0;

  nios2_debug_cmd_bridge dut (
    .clk(clk), .reset_n(reset_n), .ir_in(ir_in), .sr(sr),
    .vs_udr(vs_udr), .vs_uir(vs_uir), .flush(flush),
    .overflow_clr(overflow_clr), .cmd_ready(cmd_ready),
    .cmd_valid(cmd_valid), .cmd_ir(cmd_ir), .cmd_data(cmd_data),
    .take_action(take_action), .take_no_action(take_no_action),
    .fifo_level(fifo_level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] exp_act(input logic [39:0] e);
    return e[37] ? (4'b0001 << e[39:38]) : 4'b0000;
  endfunction

  function automatic logic [3:0] exp_nact(input logic [39:0] e);
    return e[37] ? 4'b0000 : (4'b0001 << e[39:38]);
  endfunction

  task automatic apply_reset(input logic udr_hi);
    @(negedge clk);
    vs_udr = udr_hi; vs_uir = 1'b0; cmd_ready = 1'b0;
    flush = 1'b0; overflow_clr = 1'b0;
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    sb.delete();
    cur_ir = '0;
  endtask

  task automatic do_uir(input logic [1:0] ir);
    @(negedge clk);
    ir_in = ir; vs_uir = 1'b1;
    repeat (4) @(negedge clk);
    vs_uir = 1'b0;
    repeat (5) @(negedge clk);
    cur_ir = ir;
  endtask

  task automatic do_udr(input logic [37:0] d);
    @(negedge clk);
    sr = d; vs_udr = 1'b1;
    repeat (4) @(negedge clk);
    vs_udr = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  // Pops one command and reports what was seen: head before the pop,
  // pulses in the following cycle, and pulses one cycle after that.
  task automatic pop_one(output logic vld, output logic [39:0] hd,
                         output logic [3:0] act, output logic [3:0] nact,
                         output logic [3:0] later);
    @(negedge clk);
    vld = cmd_valid; hd = {cmd_ir, cmd_data}; cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0; act = take_action; nact = take_no_action;
    @(negedge clk);
    later = take_action | take_no_action;
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({cmd_valid, fifo_level, take_action, take_no_action, overflow, cmd_ir, cmd_data} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got valid=%b lvl=%0d act=%b nact=%b ovf=%b ir=%0d data=%h, want all 0",
               cmd_valid, fifo_level, take_action, take_no_action, overflow, cmd_ir, cmd_data);
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    n_cmp++;
    if (fifo_level !== 3'd0 || cmd_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle: got lvl=%0d valid=%b, want 0/0", fifo_level, cmd_valid);
    end
  endtask

  task automatic test_action_latency();
    logic got;
    int n;
    logic vld;
    logic [39:0] hd, e;
    logic [3:0] act, nact, later;
    do_uir(2'b01);
    @(negedge clk);
    sr = 38'h20_0000_0ABC; vs_udr = 1'b1;
    sb.push_back({cur_ir, sr});
    @(posedge clk);  // first edge sampling vs_udr high
    got = 1'b0; n = 0;
    for (int k = 1; k <= 10 && !got; k++) begin
      @(posedge clk); #1;
      if (cmd_valid) begin got = 1'b1; n = k; end
    end
    n_cmp++;
    if (n != 3) begin
      n_err++;
      $display("FAIL push_latency: cmd_valid after %0d edges (0 = never), want 3", n);
    end
    n_cmp++;
    if (cmd_ir !== 2'd1 || cmd_data !== 38'h20_0000_0ABC) begin
      n_err++;
      $display("FAIL head_contents: got ir=%0d data=%h, want ir=1 data=2000000abc", cmd_ir, cmd_data);
    end
    @(negedge clk); vs_udr = 1'b0;
    repeat (5) @(negedge clk);
    pop_one(vld, hd, act, nact, later);
    e = sb.pop_front();
    n_cmp++;
    if (vld !== 1'b1 || hd !== e) begin
      n_err++;
      $display("FAIL action_head: got vld=%b %h, want 1 %h", vld, hd, e);
    end
    n_cmp++;
    if (act !== 4'b0010 || nact !== 4'b0000 || later !== 4'b0000) begin
      n_err++;
      $display("FAIL action_pulse: got act=%b nact=%b next=%b, want 0010 0000 0000", act, nact, later);
    end
  endtask

  task automatic test_no_action();
    logic vld;
    logic [39:0] hd, e;
    logic [3:0] act, nact, later;
    do_uir(2'b11);
    do_udr(38'h01_2345_6789);
    sb.push_back({cur_ir, 38'h01_2345_6789});
    pop_one(vld, hd, act, nact, later);
    e = sb.pop_front();
    n_cmp++;
    if (vld !== 1'b1 || hd !== e) begin
      n_err++;
      $display("FAIL no_action_head: got vld=%b %h, want 1 %h", vld, hd, e);
    end
    n_cmp++;
    if (nact !== exp_nact(e) || act !== 4'b0000 || later !== 4'b0000) begin
      n_err++;
      $display("FAIL no_action_pulse: got act=%b nact=%b next=%b, want 0000 %b 0000",
               act, nact, later, exp_nact(e));
    end
  endtask

  task automatic test_overflow();
    logic exp_ovf = 1'b0;
    logic [37:0] d;
    logic [39:0] e, prev;
    cmd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      do_uir(2'(i));
      d = {1'(i % 2), 37'(i * 17 + 5)};
      do_udr(d);
      if (sb.size() < 4) sb.push_back({cur_ir, d});
      else exp_ovf = 1'b1;
    end
    n_cmp++;
    if (fifo_level !== 3'd4 || overflow !== exp_ovf) begin
      n_err++;
      $display("FAIL overflow_fill: got lvl=%0d ovf=%b, want 4 %b", fifo_level, overflow, exp_ovf);
    end
    // Drain with cmd_ready held: pulses must arrive back to back.
    prev = '0;
    @(negedge clk);
    cmd_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        n_cmp++;
        if (take_action !== exp_act(prev) || take_no_action !== exp_nact(prev)) begin
          n_err++;
          $display("FAIL b2b_pulse[%0d]: got act=%b nact=%b, want %b %b", i - 1,
                   take_action, take_no_action, exp_act(prev), exp_nact(prev));
        end
      end
      if (i < 4) begin
        e = sb.pop_front();
        n_cmp++;
        if (cmd_valid !== 1'b1 || {cmd_ir, cmd_data} !== e) begin
          n_err++;
          $display("FAIL fifo_order[%0d]: got vld=%b %h, want 1 %h", i, cmd_valid, {cmd_ir, cmd_data}, e);
        end
        prev = e;
        @(negedge clk);
      end else begin
        cmd_ready = 1'b0;
      end
    end
    n_cmp++;
    if (fifo_level !== 3'd0 || overflow !== 1'b1) begin
      n_err++;
      $display("FAIL drained: got lvl=%0d ovf=%b, want 0 1", fifo_level, overflow);
    end
    @(negedge clk); overflow_clr = 1'b1;
    @(negedge clk); overflow_clr = 1'b0;
    n_cmp++;
    if (overflow !== 1'b0) begin
      n_err++;
      $display("FAIL overflow_clr: got ovf=%b, want 0", overflow);
    end
  endtask

  task automatic test_full_push_pop();
    logic [37:0] d;
    logic [39:0] hd, e;
    logic vld;
    logic [3:0] act, nact, later;
    do_uir(2'b10);
    for (int i = 0; i < 4; i++) begin
      d = {1'(i < 2), 37'(i + 100)};
      do_udr(d);
      sb.push_back({cur_ir, d});
    end
    // vs_udr rises; the push lands on the 4th edge, where cmd_ready is high.
    @(negedge clk);
    d = 38'h3F_0F0F_0F0F; sr = d; vs_udr = 1'b1;
    repeat (3) @(negedge clk);
    hd = {cmd_ir, cmd_data}; cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    e = sb.pop_front();
    sb.push_back({cur_ir, d});
    n_cmp++;
    if (fifo_level !== 3'd4 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL full_push_pop: got lvl=%0d ovf=%b, want 4 0", fifo_level, overflow);
    end
    n_cmp++;
    if (hd !== e || take_action !== exp_act(e) || take_no_action !== exp_nact(e)) begin
      n_err++;
      $display("FAIL full_pop_head: got %h act=%b nact=%b, want %h %b %b",
               hd, take_action, take_no_action, e, exp_act(e), exp_nact(e));
    end
    vs_udr = 1'b0;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      pop_one(vld, hd, act, nact, later);
      e = sb.pop_front();
      n_cmp++;
      if (vld !== 1'b1 || hd !== e || act !== exp_act(e) || nact !== exp_nact(e)) begin
        n_err++;
        $display("FAIL full_drain[%0d]: got vld=%b %h act=%b nact=%b, want 1 %h %b %b",
                 i, vld, hd, act, nact, e, exp_act(e), exp_nact(e));
      end
    end
  endtask

  task automatic test_held_through_reset();
    logic vld;
    logic [39:0] hd, e;
    logic [3:0] act, nact, later;
    apply_reset(1'b1);
    repeat (6) @(negedge clk);
    n_cmp++;
    if (fifo_level !== 3'd0 || cmd_valid !== 1'b0) begin
      n_err++;
      $display("FAIL held_udr_no_push: got lvl=%0d valid=%b, want 0 0", fifo_level, cmd_valid);
    end
    vs_udr = 1'b0;
    repeat (5) @(negedge clk);
    do_udr(38'h25_5555_AAAA);
    sb.push_back({cur_ir, 38'h25_5555_AAAA});
    n_cmp++;
    if (fifo_level !== 3'd1) begin
      n_err++;
      $display("FAIL held_udr_one_push: got lvl=%0d, want 1", fifo_level);
    end
    pop_one(vld, hd, act, nact, later);
    e = sb.pop_front();
    n_cmp++;
    if (vld !== 1'b1 || hd !== e || act !== exp_act(e)) begin
      n_err++;
      $display("FAIL held_udr_pop: got vld=%b %h act=%b, want 1 %h %b", vld, hd, act, e, exp_act(e));
    end
  endtask

  task automatic test_flush();
    do_uir(2'b10);
    do_udr(38'h21_1111_1111);
    do_udr(38'h02_2222_2222);
    n_cmp++;
    if (fifo_level !== 3'd2) begin
      n_err++;
      $display("FAIL flush_prefill: got lvl=%0d, want 2", fifo_level);
    end
    @(negedge clk);
    flush = 1'b1; cmd_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0; cmd_ready = 1'b0;
    n_cmp++;
    if (fifo_level !== 3'd0 || cmd_valid !== 1'b0 || (take_action | take_no_action) !== 4'b0000) begin
      n_err++;
      $display("FAIL flush: got lvl=%0d valid=%b act=%b nact=%b, want 0 0 0000 0000",
               fifo_level, cmd_valid, take_action, take_no_action);
    end
    @(negedge clk);
    n_cmp++;
    if ((take_action | take_no_action) !== 4'b0000) begin
      n_err++;
      $display("FAIL flush_no_pulse: got act=%b nact=%b, want 0000 0000", take_action, take_no_action);
    end
  endtask

  task automatic test_async_reset();
    do_uir(2'b01);
    do_udr(38'h3A_BCDE_F012);
    do_udr(38'h0B_0000_0001);
    n_cmp++;
    if (fifo_level !== 3'd2) begin
      n_err++;
      $display("FAIL async_prefill: got lvl=%0d, want 2", fifo_level);
    end
    @(negedge clk);
    cmd_ready = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({cmd_valid, fifo_level, take_action, take_no_action, overflow, cmd_ir, cmd_data} !== '0) begin
      n_err++;
      $display("FAIL async_reset: got valid=%b lvl=%0d act=%b nact=%b ovf=%b ir=%0d data=%h, want all 0",
               cmd_valid, fifo_level, take_action, take_no_action, overflow, cmd_ir, cmd_data);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (fifo_level !== 3'd0 || (take_action | take_no_action) !== 4'b0000) begin
      n_err++;
      $display("FAIL async_reset_after: got lvl=%0d act=%b nact=%b, want 0 0000 0000",
               fifo_level, take_action, take_no_action);
    end
    cmd_ready = 1'b0;
    sb.delete();
  endtask

  initial begin
    test_reset();
    test_action_latency();
    test_no_action();
    test_overflow();
    test_full_push_pop();
    test_held_through_reset();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
